// File: rtl/systolic_sequencer_pkg.sv
// Shared types for the systolic tile sequencer: operand width, accumulator width, FSM states.
package systolic_sequencer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 32;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        FINISH
    } seq_state_t;

endpackage

// File: rtl/systolic_sequencer_if.sv
// Control, operand-buffer and mesh-edge signals between the sequencer and its surroundings.
interface systolic_sequencer_if
    import systolic_sequencer_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned K_W = 16
) ();

    logic                  start;
    logic [K_W-1:0]        k_len;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [K_W-1:0]        rd_k;
    logic [N*DATA_W-1:0]   rd_a;
    logic [N*DATA_W-1:0]   rd_b;
    logic [N*DATA_W-1:0]   a_edge;
    logic [N*DATA_W-1:0]   b_edge;
    logic [N*N-1:0]        push;

    modport master (
        input  start, k_len, rd_a, rd_b,
        output busy, done, rd_en, rd_k, a_edge, b_edge, push
    );

    modport slave (
        output start, k_len, rd_a, rd_b,
        input  busy, done, rd_en, rd_k, a_edge, b_edge, push
    );

endinterface

// File: rtl/systolic_sequencer_skew_line.sv
// Zero-filling delay line: DEPTH registered stages, stage 0 loads 0 when its source is not valid.
module systolic_sequencer_skew_line
    import systolic_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  valid_i,
    input  data_t data_i,
    output data_t data_o
);

    data_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= valid_i ? data_i : '0;
            for (int s = 1; s < int'(DEPTH); s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_sequencer.sv
// Sequences one output-stationary C = A*B tile on an NxN PE mesh: operand reads,
// edge skew, diagonal push wavefront and a done pulse once every PE result is final.
module systolic_sequencer
    import systolic_sequencer_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned K_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    systolic_sequencer_if.master bus
);

    localparam int unsigned DIAG_W  = 2 * N - 1;
    localparam int unsigned DRAIN_W = $clog2(2 * N);
    localparam int unsigned LANE_W  = N * DATA_W;

    seq_state_t           state_q, state_d;
    logic                 rd_en_q, rd_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [K_W-1:0]       rd_k_q, rd_k_d;
    logic [K_W-1:0]       k_len_q, k_len_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 rd_vld_q;
    logic                 kick_q;
    logic [DIAG_W-1:0]    diag_q;

    data_t                a_lane [N];
    data_t                b_lane [N];
    logic [LANE_W-1:0]    a_edge_c, b_edge_c;
    logic [N*N-1:0]       push_c;

    // State, counters, read-valid tracking and the push diagonal shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_k_q   <= '0;
            k_len_q  <= '0;
            drain_q  <= '0;
            rd_vld_q <= 1'b0;
            kick_q   <= 1'b0;
            diag_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_en_q  <= rd_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_k_q   <= rd_k_d;
            k_len_q  <= k_len_d;
            drain_q  <= drain_d;
            rd_vld_q <= rd_en_q;
            kick_q   <= rd_en_q && (rd_k_q == '0);
            diag_q   <= DIAG_W'({diag_q, kick_q});
        end
    end

    // Next state; the drain phase waits out the 2N-cycle tail to the far-corner PE.
    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b0;
        rd_k_d  = rd_k_q;
        k_len_d = k_len_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    k_len_d = bus.k_len;
                    rd_k_d  = '0;
                    if (bus.k_len == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = FEED;
                        rd_en_d = 1'b1;
                    end
                end
            end
            FEED: begin
                if (rd_k_q == k_len_q - K_W'(1)) begin
                    state_d = DRAIN;
                    rd_k_d  = '0;
                    drain_d = '0;
                end else begin
                    rd_en_d = 1'b1;
                    rd_k_d  = rd_k_q + K_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_W'(2 * N - 1)) begin
                    state_d = FINISH;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    // Lane i gets i+1 stages so row/column i enters the mesh i cycles after lane 0.
    for (genvar i = 0; i < N; i++) begin : gen_lane
        systolic_sequencer_skew_line #(.DEPTH(i + 1)) u_skew_a (
            .clk     (clk),
            .reset   (reset),
            .valid_i (rd_vld_q),
            .data_i  (data_t'(bus.rd_a[DATA_W*i +: DATA_W])),
            .data_o  (a_lane[i])
        );
        systolic_sequencer_skew_line #(.DEPTH(i + 1)) u_skew_b (
            .clk     (clk),
            .reset   (reset),
            .valid_i (rd_vld_q),
            .data_i  (data_t'(bus.rd_b[DATA_W*i +: DATA_W])),
            .data_o  (b_lane[i])
        );
    end

    always_comb begin
        a_edge_c = '0;
        b_edge_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            a_edge_c[DATA_W*i +: DATA_W] = a_lane[i];
            b_edge_c[DATA_W*i +: DATA_W] = b_lane[i];
        end
    end

    // PE(i,j) restarts on anti-diagonal i+j of the wavefront.
    always_comb begin
        push_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                push_c[i*N+j] = diag_q[i+j];
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.rd_en  = rd_en_q;
    assign bus.rd_k   = rd_k_q;
    assign bus.a_edge = a_edge_c;
    assign bus.b_edge = b_edge_c;
    assign bus.push   = push_c;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Sequencer + behavioural 4x4 PE mesh + 1-cycle operand RAM, checked every cycle against a tile-level model.
module tb_systolic_sequencer;
    import systolic_sequencer_pkg::*;

    localparam int unsigned N    = 4;
    localparam int unsigned K_W  = 16;
    localparam int          KMAX = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    systolic_sequencer_if #(.N(N), .K_W(K_W)) bus ();
    systolic_sequencer #(.N(N), .K_W(K_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    // ram_a[i][k] = A[i][k], ram_b[j][k] = B[k][j]
    data_t ram_a [N][KMAX];
    data_t ram_b [N][KMAX];

    always @(posedge clk) begin
        if (bus.rd_en) begin
            for (int l = 0; l < int'(N); l++) begin
                bus.rd_a[DATA_W*l +: DATA_W] <= ram_a[l][bus.rd_k[9:0]];
                bus.rd_b[DATA_W*l +: DATA_W] <= ram_b[l][bus.rd_k[9:0]];
            end
        end
    end

    // PE mesh: operands flow right/down, accumulator restarts on push.
    data_t pa [N][N];
    data_t pb [N][N];
    logic signed [ACC_W-1:0] acc [N][N];

    function automatic data_t in_a(input int i, input int j);
        if (j == 0) return data_t'(bus.a_edge[DATA_W*i +: DATA_W]);
        return pa[i][(j > 0) ? j - 1 : 0];
    endfunction

    function automatic data_t in_b(input int i, input int j);
        if (i == 0) return data_t'(bus.b_edge[DATA_W*j +: DATA_W]);
        return pb[(i > 0) ? i - 1 : 0][j];
    endfunction

    function automatic logic signed [ACC_W-1:0] prod(input int i, input int j);
        logic signed [ACC_W-1:0] a32, b32;
        a32 = ACC_W'(in_a(i, j));
        b32 = ACC_W'(in_b(i, j));
        return a32 * b32;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                if (reset) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= '0;
                end else begin
                    pa[i][j]  <= in_a(i, j);
                    pb[i][j]  <= in_b(i, j);
                    acc[i][j] <= (bus.push[i*N+j] ? '0 : acc[i][j]) + prod(i, j);
                end
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // Tile-level reference: one record of the last accepted tile.
    int cyc = 0;
    bit tv  = 1'b0;
    int ts  = 0;
    int tk  = 0;
    int exp_c [N][N];

    function automatic int done_at();
        return (tk == 0) ? ts + 1 : ts + 2 * N + tk + 1;
    endfunction

    function automatic bit mbusy(input int t);
        return tv && (t >= ts + 1) && (t <= done_at());
    endfunction

    initial begin
        for (int i = 0; i < int'(N); i++)
            for (int j = 0; j < int'(N); j++) exp_c[i][j] = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                tv = 1'b0;
                for (int i = 0; i < int'(N); i++)
                    for (int j = 0; j < int'(N); j++) exp_c[i][j] = 0;
            end else if (bus.start && !mbusy(cyc)) begin
                tv = 1'b1;
                ts = cyc;
                tk = int'(bus.k_len);
            end
            cyc++;
        end
    end

    // Compare DUT outputs and mesh results with the model every cycle.
    initial begin : cmp_proc
        int t, kk, bi, bj, sum;
        logic [N*DATA_W-1:0] ea_x, eb_x;
        logic [N*N-1:0] ep;
        bit e_busy, e_done, e_rd;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                t      = cyc;
                e_busy = mbusy(t);
                e_done = tv && (t == done_at());
                e_rd   = tv && (tk > 0) && (t >= ts + 1) && (t <= ts + tk);
                ea_x   = '0;
                eb_x   = '0;
                ep     = '0;
                for (int l = 0; l < int'(N); l++) begin
                    kk = t - (ts + 3) - l;
                    if (tv && kk >= 0 && kk < tk) begin
                        ea_x[DATA_W*l +: DATA_W] = ram_a[l][kk];
                        eb_x[DATA_W*l +: DATA_W] = ram_b[l][kk];
                    end
                end
                for (int i = 0; i < int'(N); i++)
                    for (int j = 0; j < int'(N); j++)
                        ep[i*N+j] = tv && (tk > 0) && (t == ts + 3 + i + j);
                chk("busy", longint'(bus.busy), longint'(e_busy));
                chk("done", longint'(bus.done), longint'(e_done));
                chk("rd_en", longint'(bus.rd_en), longint'(e_rd));
                if (e_rd) chk("rd_k", longint'(bus.rd_k), longint'(t - ts - 1));
                chk("a_edge", longint'(bus.a_edge), longint'(ea_x));
                chk("b_edge", longint'(bus.b_edge), longint'(eb_x));
                chk("push", longint'(bus.push), longint'(ep));
                if (e_done && tk > 0) begin
                    for (int i = 0; i < int'(N); i++)
                        for (int j = 0; j < int'(N); j++) begin
                            sum = 0;
                            for (int k = 0; k < tk; k++)
                                sum += int'(ram_a[i][k]) * int'(ram_b[j][k]);
                            exp_c[i][j] = sum;
                        end
                end
                if (e_done || !e_busy) begin
                    bi = 0;
                    bj = 0;
                    for (int i = N - 1; i >= 0; i--)
                        for (int j = N - 1; j >= 0; j--)
                            if (acc[i][j] != exp_c[i][j]) begin
                                bi = i;
                                bj = j;
                            end
                    chk($sformatf("out_c[%0d][%0d]", bi, bj), longint'(acc[bi][bj]),
                        longint'(exp_c[bi][bj]));
                end
            end
        end
    end

    int rd_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (bus.rd_en) rd_cnt++;
    end

    task automatic fill_const(input int av, input int bv);
        for (int l = 0; l < int'(N); l++)
            for (int k = 0; k < KMAX; k++) begin
                ram_a[l][k] = data_t'(av);
                ram_b[l][k] = data_t'(bv);
            end
    endtask

    task automatic fill_rand();
        for (int l = 0; l < int'(N); l++)
            for (int k = 0; k < 16; k++) begin
                ram_a[l][k] = data_t'($urandom);
                ram_b[l][k] = data_t'($urandom);
            end
    endtask

    task automatic start_tile(input int k, output int s);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.k_len = K_W'(k);
        s = cyc;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic pulse_start(input int k);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.k_len = K_W'(k);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int d);
        d = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.done) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout cyc=%0d got=none want=done within %0d", cyc, budget);
        end
    endtask

    task automatic chk_all_c(input string nm, input int v);
        for (int i = 0; i < int'(N); i++)
            for (int j = 0; j < int'(N); j++)
                chk($sformatf("%s[%0d][%0d]", nm, i, j), longint'(acc[i][j]), longint'(v));
    endtask

    initial begin : driver
        int s, d, k;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.k_len = '0;
        fill_const(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_rd_en", longint'(bus.rd_en), 0);
        chk("rst_push", longint'(bus.push), 0);
        chk("rst_a_edge", longint'(bus.a_edge), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // 1: all-ones A, all-twos B, K=4
        fill_const(1, 2);
        rd_cnt = 0;
        start_tile(4, s);
        wait_done(100, d);
        chk("t1_done_cyc", d, s + 13);
        chk("t1_rd_cnt", rd_cnt, 4);
        chk_all_c("t1_c", 8);

        // 2: identity A -> C equals B
        for (int l = 0; l < int'(N); l++)
            for (int kk = 0; kk < 4; kk++) begin
                ram_a[l][kk] = data_t'((l == kk) ? 1 : 0);
                ram_b[l][kk] = data_t'(kk * 4 + l);
            end
        start_tile(4, s);
        wait_done(100, d);
        for (int i = 0; i < int'(N); i++)
            for (int j = 0; j < int'(N); j++)
                chk("t2_c", longint'(acc[i][j]), longint'(i * 4 + j));

        // 3: back-to-back tiles, stray starts while busy
        fill_const(1, 1);
        start_tile(4, s);
        wait_done(100, d);
        chk_all_c("t3a_c", 4);
        fill_const(-128, -128);
        rd_cnt = 0;
        start_tile(2, s);
        chk("t3_start_cyc", s, d + 1);
        pulse_start(5);
        pulse_start(3);
        wait_done(100, d);
        chk("t3_done_cyc", d, s + 11);
        chk("t3_rd_cnt", rd_cnt, 2);
        chk_all_c("t3b_c", 32768);

        // 4: zero-length tile
        rd_cnt = 0;
        start_tile(0, s);
        wait_done(10, d);
        chk("t4_done_cyc", d, s + 1);
        repeat (3) @(negedge clk);
        chk("t4_rd_cnt", rd_cnt, 0);
        chk_all_c("t4_c", 32768);

        // 5: reset mid-tile, then a fresh K=1 tile
        fill_rand();
        start_tile(8, s);
        while (cyc < s + 6) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_busy", longint'(bus.busy), 0);
        chk("t5_rd_en", longint'(bus.rd_en), 0);
        chk("t5_push", longint'(bus.push), 0);
        chk("t5_b_edge", longint'(bus.b_edge), 0);
        repeat (25) @(negedge clk);
        fill_rand();
        start_tile(1, s);
        wait_done(100, d);
        chk("t5_done_cyc", d, s + 10);
        for (int i = 0; i < int'(N); i++)
            for (int j = 0; j < int'(N); j++)
                chk("t5_c", longint'(acc[i][j]),
                    longint'(int'(ram_a[i][0]) * int'(ram_b[j][0])));

        // 6: long reduction
        fill_const(127, -128);
        start_tile(1000, s);
        wait_done(1100, d);
        chk("t6_busy_at_done", longint'(bus.busy), 1);
        chk("t6_done_cyc", d, s + 1009);
        chk_all_c("t6_c", -16256000);

        // random tiles with stray starts
        for (int r = 0; r < 12; r++) begin
            fill_rand();
            k = $urandom_range(0, 12);
            rd_cnt = 0;
            start_tile(k, s);
            if (k > 3) pulse_start($urandom_range(0, 12));
            wait_done(100, d);
            chk("rnd_rd_cnt", rd_cnt, k);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
